// File: rtl/exe_wb_mc.sv
// exe_wb_mc: multi-cycle execute/writeback stage.
// Accepts one executed instruction per handshake and emits its side effects as
// one-cycle registered strobes: GPR write + scoreboard unlock, SP/IH/RA write,
// branch redirect + flush, and a blocking data-memory access with timeout.
// Optional feature: define EXE_WB_PENDING_EN to add pend_valid/pend_addr, which
// flag an in-flight load destination for the hazard unit.
// MEM_TIMEOUT must lie in 1 .. 2**TMO_W-1.

module exe_wb_mc #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned RA_W        = 3,
    parameter int unsigned TMO_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_flag,
    input  logic              is_branch,
    input  logic              reg_wr,
    input  logic [RA_W-1:0]   reg_addr,
    input  logic [2:0]        spec_wr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              pc_switch_ctrl,
    output logic [DATA_W-1:0] new_pc,
    output logic              clear_flow,
    output logic              unlock_reg,
    output logic [RA_W-1:0]   unlock_reg_addr,
    output logic              write_reg_ctrl,
    output logic [RA_W-1:0]   write_reg_addr,
    output logic [DATA_W-1:0] write_reg_data,
    output logic              wrsp,
    output logic              wrih,
    output logic              wrra,
    output logic [DATA_W-1:0] sp_reg_data
`ifdef EXE_WB_PENDING_EN
    ,
    output logic              pend_valid,
    output logic [RA_W-1:0]   pend_addr
`endif
);

    typedef enum logic [0:0] {StIdle, StMem} state_e;

    localparam logic [TMO_W-1:0] TmoLimit = TMO_W'(MEM_TIMEOUT);

    state_e            state_q;
    logic [TMO_W-1:0]  cnt_q;
    logic [TMO_W-1:0]  cnt_d;
    logic              lat_ld_q;
    logic              lat_reg_wr_q;
    logic [RA_W-1:0]   lat_addr_q;
    logic              accept;
    logic              is_mem;

    assign accept = in_valid & in_ready;
    assign is_mem = mem_rd | mem_wr;

    // Saturating wait counter; reaching TmoLimit without an ack means timeout.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != TmoLimit) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // Single FSM: state, latched instruction and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            lat_ld_q        <= 1'b0;
            lat_reg_wr_q    <= 1'b0;
            lat_addr_q      <= '0;
            in_ready        <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_err         <= 1'b0;
            pc_switch_ctrl  <= 1'b0;
            new_pc          <= '0;
            clear_flow      <= 1'b0;
            unlock_reg      <= 1'b0;
            unlock_reg_addr <= '0;
            write_reg_ctrl  <= 1'b0;
            write_reg_addr  <= '0;
            write_reg_data  <= '0;
            wrsp            <= 1'b0;
            wrih            <= 1'b0;
            wrra            <= 1'b0;
            sp_reg_data     <= '0;
`ifdef EXE_WB_PENDING_EN
            pend_valid      <= 1'b0;
            pend_addr       <= '0;
`endif
        end else begin
            // Strobes default low so every event is a single-cycle pulse.
            mem_err        <= 1'b0;
            pc_switch_ctrl <= 1'b0;
            clear_flow     <= 1'b0;
            unlock_reg     <= 1'b0;
            write_reg_ctrl <= 1'b0;
            wrsp           <= 1'b0;
            wrih           <= 1'b0;
            wrra           <= 1'b0;

            case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (accept && is_mem) begin
                        // Branch and spec_wr fields of a memory op are ignored.
                        state_q      <= StMem;
                        in_ready     <= 1'b0;
                        mem_req      <= 1'b1;
                        mem_we       <= mem_wr & ~mem_rd;
                        mem_addr     <= alu_res;
                        mem_wdata    <= store_data;
                        cnt_q        <= '0;
                        lat_ld_q     <= mem_rd;
                        lat_reg_wr_q <= reg_wr;
                        lat_addr_q   <= reg_addr;
`ifdef EXE_WB_PENDING_EN
                        pend_valid   <= mem_rd & reg_wr;
                        pend_addr    <= reg_addr;
`endif
                    end else if (accept) begin
                        if (reg_wr) begin
                            write_reg_ctrl  <= 1'b1;
                            unlock_reg      <= 1'b1;
                            write_reg_addr  <= reg_addr;
                            unlock_reg_addr <= reg_addr;
                            write_reg_data  <= alu_res;
                        end
                        if (spec_wr != 3'b000) begin
                            wrsp        <= spec_wr[0];
                            wrih        <= spec_wr[1];
                            wrra        <= spec_wr[2];
                            sp_reg_data <= alu_res;
                        end
                        if (is_branch && alu_flag) begin
                            pc_switch_ctrl <= 1'b1;
                            clear_flow     <= 1'b1;
                            new_pc         <= alu_res;
                        end
                    end
                end

                StMem: begin
                    if (mem_ack) begin
                        // Ack beats a coincident timeout.
                        state_q  <= StIdle;
                        in_ready <= 1'b1;
                        mem_req  <= 1'b0;
`ifdef EXE_WB_PENDING_EN
                        pend_valid <= 1'b0;
`endif
                        if (lat_reg_wr_q) begin
                            write_reg_ctrl  <= 1'b1;
                            unlock_reg      <= 1'b1;
                            write_reg_addr  <= lat_addr_q;
                            unlock_reg_addr <= lat_addr_q;
                            // For a store the held address is the latched alu_res.
                            write_reg_data  <= lat_ld_q ? mem_rdata : mem_addr;
                        end
                    end else if (cnt_d == TmoLimit) begin
                        // Abort; still release the destination so the scoreboard drains.
                        state_q  <= StIdle;
                        in_ready <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_err  <= 1'b1;
                        cnt_q    <= cnt_d;
`ifdef EXE_WB_PENDING_EN
                        pend_valid <= 1'b0;
`endif
                        if (lat_reg_wr_q) begin
                            unlock_reg      <= 1'b1;
                            unlock_reg_addr <= lat_addr_q;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_wb_mc.sv
// Directed testbench for exe_wb_mc with immediate-assertion checks.

module tb_exe_wb_mc;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RA_W   = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_res;
    logic              alu_flag;
    logic              is_branch;
    logic              reg_wr;
    logic [RA_W-1:0]   reg_addr;
    logic [2:0]        spec_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] store_data;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;
    logic              pc_switch_ctrl;
    logic [DATA_W-1:0] new_pc;
    logic              clear_flow;
    logic              unlock_reg;
    logic [RA_W-1:0]   unlock_reg_addr;
    logic              write_reg_ctrl;
    logic [RA_W-1:0]   write_reg_addr;
    logic [DATA_W-1:0] write_reg_data;
    logic              wrsp;
    logic              wrih;
    logic              wrra;
    logic [DATA_W-1:0] sp_reg_data;
`ifdef EXE_WB_PENDING_EN
    logic              pend_valid;
    logic [RA_W-1:0]   pend_addr;
`endif

    int n_total = 0;
    int n_pass  = 0;

    exe_wb_mc #(
        .DATA_W      (16),
        .RA_W        (3),
        .TMO_W       (4),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .alu_res         (alu_res),
        .alu_flag        (alu_flag),
        .is_branch       (is_branch),
        .reg_wr          (reg_wr),
        .reg_addr        (reg_addr),
        .spec_wr         (spec_wr),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .store_data      (store_data),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .mem_err         (mem_err),
        .pc_switch_ctrl  (pc_switch_ctrl),
        .new_pc          (new_pc),
        .clear_flow      (clear_flow),
        .unlock_reg      (unlock_reg),
        .unlock_reg_addr (unlock_reg_addr),
        .write_reg_ctrl  (write_reg_ctrl),
        .write_reg_addr  (write_reg_addr),
        .write_reg_data  (write_reg_data),
        .wrsp            (wrsp),
        .wrih            (wrih),
        .wrra            (wrra),
        .sp_reg_data     (sp_reg_data)
`ifdef EXE_WB_PENDING_EN
        ,
        .pend_valid      (pend_valid),
        .pend_addr       (pend_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        alu_res    = '0;
        alu_flag   = 1'b0;
        is_branch  = 1'b0;
        reg_wr     = 1'b0;
        reg_addr   = '0;
        spec_wr    = 3'b000;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        store_data = '0;
    endtask

    initial begin
        idle_inputs();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        rst       = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wr_ctrl", write_reg_ctrl, 0);
        chk("rst_new_pc", new_pc, 0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1);

        // ALU writeback to R3
        in_valid = 1'b1; reg_wr = 1'b1; reg_addr = 3'd3; alu_res = 16'h1234;
        tick();
        idle_inputs();
        chk("wb_ctrl", write_reg_ctrl, 1);
        chk("wb_unlock", unlock_reg, 1);
        chk("wb_addr", write_reg_addr, 3);
        chk("wb_unlock_addr", unlock_reg_addr, 3);
        chk("wb_data", write_reg_data, 16'h1234);
        tick();
        chk("wb_ctrl_pulse", write_reg_ctrl, 0);
        chk("wb_unlock_pulse", unlock_reg, 0);

        // Taken branch, then not-taken branch
        in_valid = 1'b1; is_branch = 1'b1; alu_flag = 1'b1; alu_res = 16'h0040;
        tick();
        chk("br_switch", pc_switch_ctrl, 1);
        chk("br_clear", clear_flow, 1);
        chk("br_pc", new_pc, 16'h0040);
        alu_flag = 1'b0;
        tick();
        idle_inputs();
        chk("brnt_switch", pc_switch_ctrl, 0);
        chk("brnt_clear", clear_flow, 0);

        // Special registers SP + RA
        in_valid = 1'b1; spec_wr = 3'b101; alu_res = 16'h00FF;
        tick();
        idle_inputs();
        chk("sp_wrsp", wrsp, 1);
        chk("sp_wrih", wrih, 0);
        chk("sp_wrra", wrra, 1);
        chk("sp_data", sp_reg_data, 16'h00FF);
        tick();
        chk("sp_wrsp_pulse", wrsp, 0);
        chk("sp_wrra_pulse", wrra, 0);

        // Ack while idle has no effect
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_req", mem_req, 0);
        chk("idle_ack_wr", write_reg_ctrl, 0);

        // Load R5 from 8000, ack in the third request cycle
        in_valid = 1'b1; mem_rd = 1'b1; reg_wr = 1'b1; reg_addr = 3'd5; alu_res = 16'h8000;
        tick();
        idle_inputs();
        chk("ld_req1", mem_req, 1);
        chk("ld_addr", mem_addr, 16'h8000);
        chk("ld_we", mem_we, 0);
        chk("ld_rdy1", in_ready, 0);
        tick();
        chk("ld_req2", mem_req, 1);
        chk("ld_rdy2", in_ready, 0);
        tick();
        chk("ld_req3", mem_req, 1);
        chk("ld_rdy3", in_ready, 0);
        chk("ld_wr_early", write_reg_ctrl, 0);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk("ld_req_drop", mem_req, 0);
        chk("ld_wr", write_reg_ctrl, 1);
        chk("ld_unlock", unlock_reg, 1);
        chk("ld_wr_addr", write_reg_addr, 5);
        chk("ld_wr_data", write_reg_data, 16'hBEEF);
        chk("ld_rdy_back", in_ready, 1);
        chk("ld_err", mem_err, 0);

        // Store with ack withheld: 15 request cycles then timeout
        in_valid = 1'b1; mem_wr = 1'b1; alu_res = 16'h0100; store_data = 16'h5555;
        tick();
        idle_inputs();
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 16'h5555);
        for (int i = 2; i <= 15; i++) begin
            tick();
            chk("st_req_held", mem_req, 1);
            chk("st_no_err", mem_err, 0);
        end
        tick();
        chk("st_tmo_err", mem_err, 1);
        chk("st_tmo_req", mem_req, 0);
        chk("st_tmo_wr", write_reg_ctrl, 0);
        chk("st_tmo_unlock", unlock_reg, 0);
        tick();
        chk("st_err_pulse", mem_err, 0);

        // Load to R6 with timeout: unlock only
        in_valid = 1'b1; mem_rd = 1'b1; reg_wr = 1'b1; reg_addr = 3'd6; alu_res = 16'h0300;
        tick();
        idle_inputs();
        for (int i = 2; i <= 15; i++) begin
            tick();
        end
        chk("ldt_req_last", mem_req, 1);
        tick();
        chk("ldt_err", mem_err, 1);
        chk("ldt_unlock", unlock_reg, 1);
        chk("ldt_unlock_addr", unlock_reg_addr, 6);
        chk("ldt_wr", write_reg_ctrl, 0);

        // Ack coincident with the 15th wait cycle; rd+wr both set acts as a load
        in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1; reg_wr = 1'b1; reg_addr = 3'd2;
        alu_res = 16'h0200;
        tick();
        idle_inputs();
        chk("both_we", mem_we, 0);
        for (int i = 2; i <= 15; i++) begin
            tick();
        end
        chk("co_req15", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        tick();
        mem_ack = 1'b0;
        chk("co_err", mem_err, 0);
        chk("co_wr", write_reg_ctrl, 1);
        chk("co_addr", write_reg_addr, 2);
        chk("co_data", write_reg_data, 16'hCAFE);

        // Reset during a memory access
        in_valid = 1'b1; mem_wr = 1'b1; reg_wr = 1'b1; reg_addr = 3'd4; alu_res = 16'h0400;
        tick();
        idle_inputs();
        tick();
        chk("rm_req", mem_req, 1);
        rst = 1'b1;
        tick();
        chk("rm_req_drop", mem_req, 0);
        chk("rm_addr", mem_addr, 0);
        chk("rm_unlock", unlock_reg, 0);
        chk("rm_wr", write_reg_ctrl, 0);
        chk("rm_err", mem_err, 0);
        chk("rm_rdy", in_ready, 0);
        rst = 1'b0;
        tick();
        chk("rm_rdy_back", in_ready, 1);
        chk("rm_req_stays", mem_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
